// File: rtl/alu_operand_stage_if.sv
// ==========================================================================
// Module      : alu_operand_stage_if
// Description : Decode-to-execute bundle for the ALU operand stage.
// Revision    : 1.0 - initial release
// ==========================================================================
`default_nettype none

interface alu_operand_stage_if;
  logic        iValid;
  logic [4:0]  iRs;
  logic [4:0]  iRt;
  logic [4:0]  iRd;
  logic [31:0] iRsData;
  logic [31:0] iRtData;
  logic [31:0] iImm;
  logic        iALUSrcA;
  logic        iALUSrcB;
  logic [5:0]  iALUFun;
  logic        iSign;
  logic        iMemRead;
  logic [4:0]  iExMemRd;
  logic [31:0] iExMemResult;
  logic [4:0]  iMemWbRd;
  logic [31:0] iMemWbResult;
  logic        iFlush;
  logic        iHold;
  logic [31:0] oA;
  logic [31:0] oB;
  logic [31:0] oStoreData;
  logic [5:0]  oALUFun;
  logic        oSign;
  logic        oValid;
  logic [4:0]  oRd;
  logic        oMemRead;
  logic        oStall;

  modport master (
    output iValid, iRs, iRt, iRd, iRsData, iRtData, iImm, iALUSrcA, iALUSrcB,
           iALUFun, iSign, iMemRead, iExMemRd, iExMemResult, iMemWbRd,
           iMemWbResult, iFlush, iHold,
    input  oA, oB, oStoreData, oALUFun, oSign, oValid, oRd, oMemRead, oStall
  );

  modport slave (
    input  iValid, iRs, iRt, iRd, iRsData, iRtData, iImm, iALUSrcA, iALUSrcB,
           iALUFun, iSign, iMemRead, iExMemRd, iExMemResult, iMemWbRd,
           iMemWbResult, iFlush, iHold,
    output oA, oB, oStoreData, oALUFun, oSign, oValid, oRd, oMemRead, oStall
  );
endinterface

`default_nettype wire

// File: rtl/alu_operand_stage.sv
// ==========================================================================
// Module      : alu_operand_stage
// Description : ID/EX stage register with operand forwarding and load-use stall.
// Revision    : 1.0 - initial release
// ==========================================================================
`default_nettype none

module alu_operand_stage (
  input  logic                 iClk,
  input  logic                 iReset,
  alu_operand_stage_if.slave   bus
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic        aluSrcA;
    logic        aluSrcB;
    logic [5:0]  aluFun;
    logic        sign;
    logic        memRead;
  } stage_t;

  localparam stage_t c_BUBBLE = '0;

  stage_t      r_stage;
  stage_t      w_capture;
  logic        w_stall;
  logic [31:0] w_fwdRs;
  logic [31:0] w_fwdRt;

  always_comb begin
    w_capture         = c_BUBBLE;
    w_capture.valid   = bus.iValid;
    w_capture.rs      = bus.iRs;
    w_capture.rt      = bus.iRt;
    w_capture.rd      = bus.iRd;
    w_capture.rsData  = bus.iRsData;
    w_capture.rtData  = bus.iRtData;
    w_capture.imm     = bus.iImm;
    w_capture.aluSrcA = bus.iALUSrcA;
    w_capture.aluSrcB = bus.iALUSrcB;
    w_capture.aluFun  = bus.iALUFun;
    w_capture.sign    = bus.iSign;
    w_capture.memRead = bus.iMemRead;
  end

  // A load in this stage whose result is needed by the instruction in decode.
  assign w_stall = r_stage.valid && r_stage.memRead && (r_stage.rd != 5'd0) &&
                   bus.iValid && !bus.iFlush &&
                   ((r_stage.rd == bus.iRs) || (r_stage.rd == bus.iRt));

  always_ff @(posedge iClk) begin
    if (iReset)
      r_stage <= c_BUBBLE;
    else if (bus.iFlush)
      r_stage <= c_BUBBLE;
    else if (bus.iHold)
      r_stage <= r_stage;
    else if (w_stall)
      r_stage <= c_BUBBLE;
    else
      r_stage <= w_capture;
  end

  // Register 0 is hard-wired, so it never takes a bypassed value.
  function automatic logic [31:0] fwd(
    input logic [4:0]  regNum,
    input logic [31:0] regData,
    input logic [4:0]  exMemRd,
    input logic [31:0] exMemResult,
    input logic [4:0]  memWbRd,
    input logic [31:0] memWbResult
  );
    if (regNum != 5'd0 && regNum == exMemRd)
      return exMemResult;
    else if (regNum != 5'd0 && regNum == memWbRd)
      return memWbResult;
    else
      return regData;
  endfunction

  assign w_fwdRs = fwd(r_stage.rs, r_stage.rsData, bus.iExMemRd, bus.iExMemResult,
                       bus.iMemWbRd, bus.iMemWbResult);
  assign w_fwdRt = fwd(r_stage.rt, r_stage.rtData, bus.iExMemRd, bus.iExMemResult,
                       bus.iMemWbRd, bus.iMemWbResult);

  assign bus.oA         = r_stage.aluSrcA ? {27'd0, r_stage.imm[10:6]} : w_fwdRs;
  assign bus.oB         = r_stage.aluSrcB ? r_stage.imm : w_fwdRt;
  assign bus.oStoreData = w_fwdRt;
  assign bus.oALUFun    = r_stage.aluFun;
  assign bus.oSign      = r_stage.sign;
  assign bus.oValid     = r_stage.valid;
  assign bus.oRd        = r_stage.rd;
  assign bus.oMemRead   = r_stage.memRead;
  assign bus.oStall     = w_stall;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
// ==========================================================================
// Module      : tb_alu_operand_stage
// Description : Directed scoreboard bench for the ALU operand stage.
// Revision    : 1.0 - initial release
// ==========================================================================
`default_nettype none

module tb_alu_operand_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  alu_operand_stage_if bus ();

  alu_operand_stage dut (
    .iClk   (clk),
    .iReset (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {F_A, F_B, F_ST, F_FUN, F_SIGN, F_VALID, F_RD, F_MR, F_STALL} field_t;
  typedef struct {
    int          cyc;
    string       name;
    field_t      f;
    logic [31:0] v;
  } exp_t;

  exp_t sbq[$];

  function automatic void pushExp(input int d, input string n, input field_t f,
                                  input logic [31:0] v);
    exp_t e;
    e.cyc  = cyc + d;
    e.name = n;
    e.f    = f;
    e.v    = v;
    sbq.push_back(e);
  endfunction

  function automatic logic [31:0] fieldVal(input field_t f);
    case (f)
      F_A:     return bus.oA;
      F_B:     return bus.oB;
      F_ST:    return bus.oStoreData;
      F_FUN:   return {26'd0, bus.oALUFun};
      F_SIGN:  return {31'd0, bus.oSign};
      F_VALID: return {31'd0, bus.oValid};
      F_RD:    return {27'd0, bus.oRd};
      F_MR:    return {31'd0, bus.oMemRead};
      default: return {31'd0, bus.oStall};
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle, away from the edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e   = sbq.pop_front();
      act = fieldVal(e.f);
      checks++;
      if (e.cyc != cyc || act !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                 e.name, act, e.v, cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [31:0] rsD,
                      input logic [31:0] rtD, input logic [31:0] imm,
                      input logic srcA, input logic srcB, input logic [5:0] fun,
                      input logic sgn, input logic mr);
    bus.iValid   = v;
    bus.iRs      = rs;
    bus.iRt      = rt;
    bus.iRd      = rd;
    bus.iRsData  = rsD;
    bus.iRtData  = rtD;
    bus.iImm     = imm;
    bus.iALUSrcA = srcA;
    bus.iALUSrcB = srcB;
    bus.iALUFun  = fun;
    bus.iSign    = sgn;
    bus.iMemRead = mr;
  endtask

  task automatic fwdSet(input logic [4:0] exRd, input logic [31:0] exRes,
                        input logic [4:0] wbRd, input logic [31:0] wbRes);
    bus.iExMemRd     = exRd;
    bus.iExMemResult = exRes;
    bus.iMemWbRd     = wbRd;
    bus.iMemWbResult = wbRes;
  endtask

  task automatic loadThenUse(input logic flush, input logic hold);
    slot(1, 5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 32'h0, 0, 0, 6'h23, 0, 1);
    step();
    slot(1, 5'd3, 5'd8, 5'd4, 32'h33, 32'h44, 32'h0, 0, 0, 6'h20, 0, 0);
    bus.iFlush = flush;
    bus.iHold  = hold;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    slot(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'h0, 0, 0);
    fwdSet(0, 0, 0, 0);
    bus.iFlush = 0;
    bus.iHold  = 0;
    step();
    step();
    pushExp(0, "rst_valid", F_VALID, 0);
    pushExp(0, "rst_rd", F_RD, 0);
    pushExp(0, "rst_memread", F_MR, 0);
    pushExp(0, "rst_fun", F_FUN, 0);
    pushExp(0, "rst_sign", F_SIGN, 0);
    pushExp(0, "rst_a", F_A, 0);
    pushExp(0, "rst_b", F_B, 0);
    pushExp(0, "rst_store", F_ST, 0);
    pushExp(0, "rst_stall", F_STALL, 0);
    rst = 0;

    // Forwarding priority, then a three-cycle hold with changing inputs
    slot(1, 5'd5, 5'd6, 5'd9, 32'h1, 32'h2, 32'h0, 0, 0, 6'h21, 1, 0);
    fwdSet(5'd5, 32'hAA, 5'd5, 32'hBB);
    pushExp(1, "fwd_exmem_a", F_A, 32'hAA);
    pushExp(1, "fwd_b_nomatch", F_B, 32'h2);
    pushExp(1, "fwd_store", F_ST, 32'h2);
    pushExp(1, "cap_fun", F_FUN, 32'h21);
    pushExp(1, "cap_sign", F_SIGN, 1);
    pushExp(1, "cap_valid", F_VALID, 1);
    pushExp(1, "cap_rd", F_RD, 9);
    step();
    bus.iHold = 1;
    step();
    slot(1, 5'd2, 5'd3, 5'd3, 32'h9, 32'h9, 32'h0, 0, 0, 6'h3F, 0, 0);
    bus.iExMemRd = 0;
    pushExp(0, "fwd_memwb_a", F_A, 32'hBB);
    pushExp(0, "hold1_fun", F_FUN, 32'h21);
    pushExp(0, "hold1_rd", F_RD, 9);
    pushExp(0, "hold1_valid", F_VALID, 1);
    step();
    slot(0, 5'd7, 5'd7, 5'd7, 32'h5, 32'h5, 32'h0, 0, 0, 6'h11, 0, 0);
    bus.iMemWbRd = 0;
    pushExp(0, "hold2_a_regdata", F_A, 32'h1);
    pushExp(0, "hold2_rd", F_RD, 9);
    pushExp(0, "hold2_valid", F_VALID, 1);
    step();
    fwdSet(0, 0, 5'd6, 32'hCC);
    pushExp(0, "hold3_b_fwd", F_B, 32'hCC);
    pushExp(0, "hold3_store_fwd", F_ST, 32'hCC);
    pushExp(0, "hold3_a", F_A, 32'h1);
    pushExp(0, "hold3_fun", F_FUN, 32'h21);
    pushExp(0, "hold3_valid", F_VALID, 1);
    step();

    // Operand select
    bus.iHold = 0;
    fwdSet(0, 0, 0, 0);
    slot(1, 5'd7, 5'd8, 5'd10, 32'h11, 32'h22, 32'h140, 1, 0, 6'h02, 0, 0);
    pushExp(1, "srca_shamt", F_A, 32'h5);
    pushExp(1, "srca_b_rt", F_B, 32'h22);
    pushExp(1, "srca_store", F_ST, 32'h22);
    step();
    slot(1, 5'd7, 5'd12, 5'd11, 32'h11, 32'h22, 32'hFFFF_FFF0, 0, 1, 6'h02, 0, 0);
    fwdSet(5'd12, 32'h77, 0, 0);
    pushExp(1, "srcb_imm", F_B, 32'hFFFF_FFF0);
    pushExp(1, "srcb_store_fwd", F_ST, 32'h77);
    pushExp(1, "srcb_a_rs", F_A, 32'h11);
    step();

    // Register 0 is never forwarded
    slot(1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0, 6'h01, 0, 0);
    step();
    fwdSet(0, 32'h1234, 0, 32'h5678);
    slot(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'h0, 0, 0);
    pushExp(0, "reg0_a", F_A, 32'h0);
    pushExp(0, "reg0_b", F_B, 32'h0);
    fwdSet(0, 0, 0, 0);
    step();

    // Load-use stall
    loadThenUse(0, 0);
    pushExp(0, "lu_stall", F_STALL, 1);
    pushExp(0, "lu_load_mr", F_MR, 1);
    pushExp(0, "lu_load_rd", F_RD, 8);
    step();
    pushExp(0, "lu_bubble_valid", F_VALID, 0);
    pushExp(0, "lu_bubble_nostall", F_STALL, 0);
    step();
    pushExp(0, "lu_cap_valid", F_VALID, 1);
    pushExp(0, "lu_cap_rd", F_RD, 4);
    pushExp(0, "lu_cap_a", F_A, 32'h33);
    pushExp(0, "lu_cap_b", F_B, 32'h44);
    pushExp(0, "lu_cap_fun", F_FUN, 32'h20);
    step();

    // Flush overrides stall
    loadThenUse(1, 0);
    pushExp(0, "fl_nostall", F_STALL, 0);
    step();
    bus.iFlush = 0;
    pushExp(0, "fl_valid", F_VALID, 0);
    pushExp(0, "fl_rd", F_RD, 0);
    pushExp(0, "fl_fun", F_FUN, 0);
    pushExp(0, "fl_memread", F_MR, 0);
    pushExp(0, "fl_a", F_A, 0);
    step();
    pushExp(0, "fl_after_valid", F_VALID, 1);
    pushExp(0, "fl_after_rd", F_RD, 4);
    step();

    // Reset while stalled and held
    loadThenUse(0, 1);
    pushExp(0, "rsth_stall", F_STALL, 1);
    step();
    pushExp(0, "rsth_held_stall", F_STALL, 1);
    pushExp(0, "rsth_held_rd", F_RD, 8);
    rst = 1;
    step();
    rst = 0;
    bus.iHold = 0;
    pushExp(0, "rsth_valid", F_VALID, 0);
    pushExp(0, "rsth_nostall", F_STALL, 0);
    pushExp(0, "rsth_rd", F_RD, 0);
    step();
    pushExp(0, "rsth_resume_valid", F_VALID, 1);
    pushExp(0, "rsth_resume_rd", F_RD, 4);
    step();

    bus.iValid = 0;
    step();
    step();
    step();
    if (sbq.size() > 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      errors += sbq.size();
      checks += sbq.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 SHALL: iClk  in  1  sole clock, rising edge.
REQ-002 SHALL: iReset  in  1  synchronous, active-high reset.
REQ-003 SHALL: iValid  in  1  decode slot holds a real instruction.
REQ-004 SHALL: iRs / iRt  in  5 each  source register numbers.
REQ-005 SHALL: iRd  in  5  destination register; 0 = no writeback.
REQ-006 SHALL: iRsData / iRtData  in  32 each  register-file read data.
REQ-007 SHALL: iImm  in  32  extended immediate; iImm[10:6] = shamt.
REQ-008 SHALL: iALUSrcA  in  1  1 = A operand is shamt.
REQ-009 SHALL: iALUSrcB  in  1  1 = B operand is iImm.
REQ-010 SHALL: iALUFun / iSign  in  6 / 1  ALU function code and signedness, passed through.
REQ-011 SHALL: iMemRead  in  1  instruction is a load.
REQ-012 SHALL: iExMemRd / iExMemResult  in  5 / 32  EX/MEM destination and result.
REQ-013 SHALL: iMemWbRd / iMemWbResult  in  5 / 32  MEM/WB destination and writeback data.
REQ-014 SHALL: iFlush  in  1  kill the incoming instruction (taken branch/jump).
REQ-015 SHALL: iHold  in  1  global freeze (memory wait).
REQ-016 SHALL: oA / oB  out  32 each  ALU operands.
REQ-017 SHALL: oStoreData  out  32  forwarded rt value for stores.
REQ-018 SHALL: oALUFun / oSign  out  6 / 1  registered ALU controls.
REQ-019 SHALL: oValid / oRd / oMemRead  out  1 / 5 / 1  registered instruction status.
REQ-020 SHALL: oStall  out  1  load-use hazard; decode and fetch hold.

Function
REQ-021 SHALL: on each rising edge, capture iRs, iRt, iRd, iRsData, iRtData, iImm, iALUSrcA, iALUSrcB, iALUFun, iSign, iMemRead and iValid into the stage register; latency is 1 cycle.
REQ-022 SHALL: apply priority per edge: iReset > iFlush > iHold > load-use bubble > normal load.
REQ-023 SHALL: on iFlush, load a bubble into the stage register: valid 0, Rd 0, MemRead 0, ALUFun 000000, Sign 0, data fields 0.
REQ-024 SHALL: on iHold without iFlush, keep all stage-register contents unchanged.
REQ-025 SHALL: drive oStall combinationally high when all of the following hold: oValid=1, oMemRead=1, oRd!=0, iValid=1, iFlush=0, and oRd equals iRs or iRt.
REQ-026 SHALL: on an oStall cycle without iHold, load a bubble (per REQ-023); the decode slot is re-presented unchanged on the next cycle.
REQ-027 SHALL: compute forwarded rs and rt combinationally from the registered register numbers.
REQ-028 SHALL: for each source register, select iExMemResult if its number equals iExMemRd and is nonzero; otherwise iMemWbResult if it equals iMemWbRd and is nonzero; otherwise the registered read data.
REQ-029 SHALL: give EX/MEM priority over MEM/WB when both match.
REQ-030 SHALL: never forward register 0, which always reads the registered data.
REQ-031 SHALL: drive oA = {27'b0, shamt} when the registered ALUSrcA = 1, else forwarded rs.
REQ-032 SHALL: drive oB = registered iImm when the registered ALUSrcB = 1, else forwarded rt.
REQ-033 SHALL: drive oStoreData = forwarded rt regardless of ALUSrcB.
REQ-034 SHALL: keep oALUFun, oSign, oValid, oRd and oMemRead purely registered, with no combinational path from inputs.
REQ-035 SHALL: drive oStall = 0 whenever oValid = 0, so a bubble never creates a stall.

Reset
REQ-036 SHALL: when iReset is high at an edge, clear the stage register to a bubble; after that edge oValid=0, oRd=0, oMemRead=0, oALUFun=000000, oSign=0, oA=0, oB=0, oStoreData=0, oStall=0.
REQ-037 SHALL: abandon any stall or hold in progress when reset is asserted mid-operation; normal load resumes on the first edge after iReset falls.

Verification
REQ-038 SHALL: Forward priority: held rs=5, rsData=1; iExMemRd=5/result=0xAA; iMemWbRd=5/result=0xBB -> oA=0xAA; after iExMemRd=0 -> oA=0xBB.
REQ-039 SHALL: Load-use: held load with rd=8; incoming iRt=8, iValid=1 -> oStall=1; next edge oValid=0; following edge the instruction is captured, oValid=1.
REQ-040 SHALL: Flush overrides stall: as REQ-039 but iFlush=1 -> oStall=0; next edge bubble captured, oValid=0.
REQ-041 SHALL: Hold: iHold=1 for 3 cycles with changing inputs -> oALUFun, oRd and oValid are unchanged; oA tracks new forwarding inputs.
REQ-042 SHALL: Operand select: ALUSrcA=1, iImm=0x00000140 -> oA=0x00000005; ALUSrcB=1, iImm=0xFFFFFFF0 -> oB=0xFFFFFFF0 while oStoreData = forwarded rt.
REQ-043 SHALL: Register 0: iRs=0, iExMemRd=0, iExMemResult=0x1234 -> oA = registered rsData (0).
